// File: rtl/branch_predictor_gshare.sv
// Branch predictor for the IF stage. It combines a direct-mapped tagged BTB,
// a gshare pattern history table of 2-bit counters and a return-address stack.
// Lookup on pc_f is purely combinational. EX-stage resolutions train all
// structures at the next rising clock edge.
module branch_predictor_gshare #(
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned GHR_BITS    = 8,
  parameter int unsigned RAS_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic [31:0] pc_e,
  input  logic        cflow_valid,
  input  logic        cflow_taken,
  input  logic [31:0] cflow_target,
  input  logic        cflow_branch,
  input  logic        cflow_call,
  input  logic        cflow_ret
);

  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W  = 32 - BTB_IW - 2;
  localparam int unsigned PHT_IW = $clog2(PHT_ENTRIES);
  localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
  localparam int unsigned RAS_CW = RAS_PW + 1;
  localparam logic [RAS_CW-1:0] RAS_FULL = RAS_CW'(RAS_DEPTH);

  typedef enum logic [1:0] {TyBr, TyJmp, TyCall, TyRet} cf_type_e;

  // BTB storage; only the valid bits need a reset.
  logic              btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q    [BTB_ENTRIES];
  logic [31:0]       btb_target_q [BTB_ENTRIES];
  cf_type_e          btb_type_q   [BTB_ENTRIES];

  logic [1:0]          pht_q [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;

  logic [31:0]       ras_q [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_ptr_q, ras_ptr_d, ras_wptr;
  logic [RAS_CW-1:0] ras_cnt_q, ras_cnt_d;
  logic              ras_push, ras_pop, ras_we;
  logic [31:0]       ras_wdata;

  logic [BTB_IW-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]  f_tag, e_tag;
  logic [PHT_IW-1:0] ghr_idx, pht_f_idx, pht_e_idx;
  logic              f_hit, la_taken;
  logic [31:0]       la_target;
  logic [1:0]        pht_old, pht_new;
  logic [GHR_BITS:0] ghr_ext;
  logic              btb_we;
  cf_type_e          e_type;

  // Instruction-alignment bits carry no information for prediction.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc_f[1:0], pc_e[1:0]};

  assign f_idx     = pc_f[BTB_IW+1:2];
  assign f_tag     = pc_f[31:BTB_IW+2];
  assign e_idx     = pc_e[BTB_IW+1:2];
  assign e_tag     = pc_e[31:BTB_IW+2];
  assign pht_f_idx = pc_f[PHT_IW+1:2] ^ ghr_idx;
  assign pht_e_idx = pc_e[PHT_IW+1:2] ^ ghr_idx;
  assign ghr_ext   = {ghr_q, cflow_taken};
  assign btb_we    = cflow_valid && cflow_taken;
  assign ras_wdata = pc_e + 32'd4;

  // History occupies the low bits of the PHT index; upper bits come from the PC only.
  always_comb begin
    ghr_idx = '0;
    ghr_idx[GHR_BITS-1:0] = ghr_q;
  end

  // Combinational lookup: BTB hit and entry type select direction and target.
  always_comb begin
    f_hit     = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    la_taken  = 1'b0;
    la_target = btb_target_q[f_idx];
    if (f_hit) begin
      unique case (btb_type_q[f_idx])
        TyBr:         la_taken = pht_q[pht_f_idx][1];
        TyJmp, TyCall: la_taken = 1'b1;
        TyRet: begin
          la_taken  = (ras_cnt_q != '0);
          la_target = ras_q[ras_ptr_q];
        end
      endcase
    end
    pred_taken  = la_taken;
    pred_target = la_taken ? la_target : (pc_f + 32'd4);
  end

  // Entry type from the resolution flags; returns win over calls, calls over branches.
  always_comb begin
    if (cflow_ret)         e_type = TyRet;
    else if (cflow_call)   e_type = TyCall;
    else if (cflow_branch) e_type = TyBr;
    else                   e_type = TyJmp;
  end

  // Saturating 2-bit counter step for the resolving branch.
  always_comb begin
    pht_old = pht_q[pht_e_idx];
    pht_new = pht_old;
    if (cflow_taken && (pht_old != 2'b11))       pht_new = pht_old + 2'd1;
    else if (!cflow_taken && (pht_old != 2'b00)) pht_new = pht_old - 2'd1;
  end

  // PHT and global history train on committed conditional branches only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
      ghr_q <= '0;
    end else if (cflow_valid && cflow_branch) begin
      pht_q[pht_e_idx] <= pht_new;
      ghr_q            <= ghr_ext[GHR_BITS-1:0];
    end
  end

  // BTB valid bits: taken resolutions allocate, not-taken leave entries alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid_q[e_idx] <= 1'b1;
    end
  end

  // BTB payload; stale contents are masked by the valid bits after reset.
  always_ff @(posedge clk) begin
    if (btb_we && !rst) begin
      btb_tag_q[e_idx]    <= e_tag;
      btb_target_q[e_idx] <= cflow_target;
      btb_type_q[e_idx]   <= e_type;
    end
  end

  // RAS pointer/count next state: pop then push; call+ret on a live stack replaces the top.
  always_comb begin
    ras_pop   = cflow_valid && cflow_ret && (ras_cnt_q != '0);
    ras_push  = cflow_valid && cflow_call;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_wptr  = ras_ptr_q;
    ras_we    = 1'b0;
    if (ras_push && ras_pop) begin
      ras_we = 1'b1;
    end else if (ras_push) begin
      ras_ptr_d = ras_ptr_q + RAS_PW'(1);
      ras_wptr  = ras_ptr_d;
      ras_we    = 1'b1;
      // On overflow the pointer wraps over the oldest entry and the count saturates.
      if (ras_cnt_q != RAS_FULL) ras_cnt_d = ras_cnt_q + RAS_CW'(1);
    end else if (ras_pop) begin
      ras_ptr_d = ras_ptr_q - RAS_PW'(1);
      ras_cnt_d = ras_cnt_q - RAS_CW'(1);
    end
  end

  // RAS pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // RAS storage write of the return address.
  always_ff @(posedge clk) begin
    if (ras_we && !rst) ras_q[ras_wptr] <= ras_wdata;
  end

endmodule
